// File: rtl/writeback_stage.sv
// Final pipeline stage: merges in-order memory-stage results with buffered
// long-latency results into the registered register-file write port.
module writeback_stage #(
    parameter int unsigned LU_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic        wb_reg_write,
    input  logic        wb_mem_to_reg,
    input  logic [2:0]  wb_funct3,
    input  logic [4:0]  wb_rd_id,
    input  logic [31:0] wb_alu_result,
    input  logic [31:0] wb_mem_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd_id,
    input  logic [31:0] lu_data,
    output logic        write_en,
    output logic [4:0]  write_id,
    output logic [31:0] write_data,
    output logic [31:0] pending_rd_mask,
    output logic        stall_pipe
);

    localparam int unsigned PTR_W = $clog2(LU_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]               fifo_rd   [LU_FIFO_DEPTH];
    logic [31:0]              fifo_data [LU_FIFO_DEPTH];
    logic [LU_FIFO_DEPTH-1:0] fifo_vld;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         starve_cnt;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pipe_req;
    logic        push;
    logic        pop;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [31:0] wb_result;

    // Ring of per-entry valid bits: the slot under each pointer tells full/empty
    assign fifo_full  = fifo_vld[wr_ptr];
    assign fifo_empty = ~fifo_vld[rd_ptr];

    assign lu_ready   = reset_n & ~fifo_full;
    assign stall_pipe = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign pipe_req   = wb_valid & wb_reg_write & (wb_rd_id != 5'd0) & ~stall_pipe;
    assign push       = lu_valid & lu_ready & (lu_rd_id != 5'd0);
    assign pop        = ~fifo_empty & ~pipe_req;

    always_comb begin
        ld_byte = 8'h00;
        case (wb_alu_result[1:0])
            2'd0: ld_byte = wb_mem_data[7:0];
            2'd1: ld_byte = wb_mem_data[15:8];
            2'd2: ld_byte = wb_mem_data[23:16];
            2'd3: ld_byte = wb_mem_data[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = wb_alu_result[1] ? wb_mem_data[31:16] : wb_mem_data[15:0];

        case (wb_funct3)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_value = {24'h000000, ld_byte};
            3'b101:  ld_value = {16'h0000, ld_half};
            default: ld_value = wb_mem_data;
        endcase
        wb_result = wb_mem_to_reg ? ld_value : wb_alu_result;
    end

    always_comb begin
        pending_rd_mask = '0;
        for (int unsigned i = 0; i < LU_FIFO_DEPTH; i++) begin
            if (fifo_vld[PTR_W'(i)]) begin
                pending_rd_mask[fifo_rd[PTR_W'(i)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lu_rd_id;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_vld   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_en   <= 1'b0;
            write_id   <= '0;
            write_data <= '0;
        end else if (pipe_req) begin
            write_en   <= 1'b1;
            write_id   <= wb_rd_id;
            write_data <= wb_result;
        end else if (pop) begin
            write_en   <= 1'b1;
            write_id   <= fifo_rd[rd_ptr];
            write_data <= fifo_data[rd_ptr];
        end else begin
            write_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: stimulus queues expected writes,
// an independent negedge monitor pops and compares every register-file write.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [2:0]  wb_funct3;
    logic [4:0]  wb_rd_id;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd_id;
    logic [31:0] lu_data;
    logic        write_en;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic [31:0] pending_rd_mask;
    logic        stall_pipe;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    writeback_stage #(
        .LU_FIFO_DEPTH(2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_funct3      (wb_funct3),
        .wb_rd_id       (wb_rd_id),
        .wb_alu_result  (wb_alu_result),
        .wb_mem_data    (wb_mem_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_rd_id       (lu_rd_id),
        .lu_data        (lu_data),
        .write_en       (write_en),
        .write_id       (write_id),
        .write_data     (write_data),
        .pending_rd_mask(pending_rd_mask),
        .stall_pipe     (stall_pipe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [4:0] id, input logic [31:0] data);
        exp_q.push_back('{id: id, data: data});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_idle();
        wb_valid      = 1'b0;
        wb_reg_write  = 1'b0;
        wb_mem_to_reg = 1'b0;
        wb_funct3     = 3'b010;
        wb_rd_id      = 5'd0;
        wb_alu_result = '0;
        wb_mem_data   = '0;
    endtask

    task automatic wb_drive(input logic [4:0] rd, input logic m2r, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] mem);
        wb_valid      = 1'b1;
        wb_reg_write  = 1'b1;
        wb_mem_to_reg = m2r;
        wb_funct3     = f3;
        wb_rd_id      = rd;
        wb_alu_result = alu;
        wb_mem_data   = mem;
    endtask

    task automatic lu_drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v;
        lu_rd_id = rd;
        lu_data  = d;
    endtask

    // Monitor: every write the DUT presents must match the head of the queue
    always @(negedge clk) begin
        wr_t e;
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got id=%0d data=0x%08h, expected no write",
                         write_id, write_data);
            end else begin
                e = exp_q.pop_front();
                check("write_id", {27'd0, write_id}, {27'd0, e.id});
                check("write_data", write_data, e.data);
            end
        end
    end

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_off [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                                32'h00007F01, 32'h80FF7F01};

    initial begin
        reset_n = 1'b0;
        wb_idle();
        lu_drive(1'b0, 5'd0, '0);

        // Reset state
        #3;
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_write_id", {27'd0, write_id}, 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_mask", pending_rd_mask, 32'd0);
        check("rst_stall", {31'd0, stall_pipe}, 32'd0);
        check("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        check("post_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        step();

        // ALU write, then rd=0 write suppressed
        wb_drive(5'd5, 1'b0, 3'b010, 32'h00001234, 32'h0);
        push_exp(5'd5, 32'h00001234);
        step();
        wb_drive(5'd0, 1'b0, 3'b010, 32'h00001234, 32'h0);
        @(negedge clk);
        check("alu_write_en", {31'd0, write_en}, 32'd1);
        step();
        wb_idle();
        @(negedge clk);
        check("rd0_no_write", {31'd0, write_en}, 32'd0);
        step();

        // Load extension
        for (int i = 0; i < 5; i++) begin
            wb_drive(5'(i + 1), 1'b1, ld_f3[i], 32'h00000100 | {30'd0, ld_off[i]}, 32'h80FF7F01);
            push_exp(5'(i + 1), ld_exp[i]);
            step();
        end
        wb_idle();
        step();
        step();

        // Long-latency result drained while the pipeline is idle
        lu_drive(1'b1, 5'd7, 32'h0000DEAD);
        push_exp(5'd7, 32'h0000DEAD);
        step();
        lu_drive(1'b0, 5'd0, '0);
        @(negedge clk);
        check("drain_mask_set", pending_rd_mask, 32'h00000080);
        check("drain_no_early_write", {31'd0, write_en}, 32'd0);
        step();
        @(negedge clk);
        check("drain_write_en", {31'd0, write_en}, 32'd1);
        check("drain_mask_clear", pending_rd_mask, 32'd0);
        step();
        step();

        // Backpressure: FIFO fills while the pipeline writes every cycle
        wb_drive(5'd20, 1'b0, 3'b010, 32'h00000A20, 32'h0);
        lu_drive(1'b1, 5'd10, 32'h0000010A);
        push_exp(5'd20, 32'h00000A20);
        step();
        wb_drive(5'd21, 1'b0, 3'b010, 32'h00000A21, 32'h0);
        lu_drive(1'b1, 5'd11, 32'h0000011B);
        push_exp(5'd21, 32'h00000A21);
        step();
        wb_drive(5'd22, 1'b0, 3'b010, 32'h00000A22, 32'h0);
        lu_drive(1'b1, 5'd12, 32'h0000012C);
        push_exp(5'd22, 32'h00000A22);
        push_exp(5'd10, 32'h0000010A);
        push_exp(5'd11, 32'h0000011B);
        push_exp(5'd12, 32'h0000012C);
        @(negedge clk);
        check("bp_full_not_ready", {31'd0, lu_ready}, 32'd0);
        check("bp_mask", pending_rd_mask, 32'h00000C00);
        step();
        wb_idle();
        @(negedge clk);
        check("bp_still_full", {31'd0, lu_ready}, 32'd0);
        step();
        @(negedge clk);
        check("bp_ready_after_pop", {31'd0, lu_ready}, 32'd1);
        step();
        lu_drive(1'b0, 5'd0, '0);
        repeat (4) step();

        // Starvation: one entry waits behind back-to-back pipeline writes
        for (int i = 0; i < 12; i++) begin
            if (i == 0) lu_drive(1'b1, 5'd9, 32'h00009999);
            else        lu_drive(1'b0, 5'd0, '0);
            if (i <= 9)       wb_drive(5'd1, 1'b0, 3'b010, 32'h00000100 + 32'(i), 32'h0);
            else if (i == 10) wb_drive(5'd1, 1'b0, 3'b010, 32'h00000109, 32'h0);
            else              wb_idle();
            if (i <= 8) push_exp(5'd1, 32'h00000100 + 32'(i));
            if (i == 9) begin
                push_exp(5'd9, 32'h00009999);
                push_exp(5'd1, 32'h00000109);
            end
            @(negedge clk);
            if (i <= 10) check($sformatf("starve_stall_c%0d", i), {31'd0, stall_pipe},
                               (i == 9) ? 32'd1 : 32'd0);
            step();
        end
        repeat (3) step();

        // Reset while the FIFO holds two entries and a write is in flight
        wb_drive(5'd2, 1'b0, 3'b010, 32'h00000202, 32'h0);
        lu_drive(1'b1, 5'd13, 32'h00000013);
        push_exp(5'd2, 32'h00000202);
        step();
        wb_drive(5'd3, 1'b0, 3'b010, 32'h00000303, 32'h0);
        lu_drive(1'b1, 5'd14, 32'h00000014);
        push_exp(5'd3, 32'h00000303);
        step();
        wb_drive(5'd4, 1'b0, 3'b010, 32'h00000404, 32'h0);
        lu_drive(1'b0, 5'd0, '0);
        @(negedge clk);
        check("midrst_mask_before", pending_rd_mask, 32'h00006000);
        #2;
        reset_n = 1'b0;
        wb_idle();
        #1;
        check("midrst_write_en", {31'd0, write_en}, 32'd0);
        check("midrst_mask", pending_rd_mask, 32'd0);
        check("midrst_lu_ready", {31'd0, lu_ready}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("midrst_ready_after", {31'd0, lu_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_stale_write", {31'd0, write_en}, 32'd0);
            step();
        end

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
